// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard detection, bubble insertion and saturating stall counter; define FORWARD_EN for the EX/MEM/WB forwarding network
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             IdValid,
  input  logic [4:0]       RsAddr,
  input  logic [4:0]       RtAddr,
  input  logic [4:0]       RdAddr,
  input  logic [31:0]      RsData,
  input  logic [31:0]      RtData,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic [31:0]      IdImm,
  input  logic             IdImmSel,
  input  logic [31:0]      ExResult,
  input  logic             MemRegWrite,
  input  logic [4:0]       MemRdAddr,
  input  logic [31:0]      MemResult,
  input  logic             WbRegWrite,
  input  logic [4:0]       WbRdAddr,
  input  logic [31:0]      WbData,
  input  logic             DownStall,
  input  logic             Flush,
  output logic             ExValid,
  output logic [4:0]       ExRdAddr,
  output logic             ExRegWrite,
  output logic             ExMemRead,
  output logic [31:0]      ExOpA,
  output logic [31:0]      ExOpB,
  output logic [31:0]      ExRtVal,
  output logic             Hold,
  output logic [CNT_W-1:0] StallCount
);
  typedef enum logic {RUN, LSTALL} state_t;
  state_t state_q, state_d;
  logic ex_valid_q, ex_valid_d, ex_reg_write_q, ex_reg_write_d, ex_mem_read_q, ex_mem_read_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, rt_val_q, rt_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rt_used, rs_nz, rt_nz, ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt, hazard, load_use;
  logic [31:0] rs_fwd, rt_fwd;
  // An immediate-form instruction that neither loads nor writes a register is a store: its Rt is the store data
  assign rt_used = ~IdImmSel | ~(IdRegWrite | IdMemRead);
  assign rs_nz = |RsAddr;
  assign rt_nz = |RtAddr;
  assign ex_rs = ex_valid_q & rs_nz & (ex_rd_q == RsAddr);
  assign ex_rt = ex_valid_q & rt_nz & (ex_rd_q == RtAddr);
  assign mem_rs = MemRegWrite & rs_nz & (MemRdAddr == RsAddr);
  assign mem_rt = MemRegWrite & rt_nz & (MemRdAddr == RtAddr);
  assign wb_rs = WbRegWrite & rs_nz & (WbRdAddr == RsAddr);
  assign wb_rt = WbRegWrite & rt_nz & (WbRdAddr == RtAddr);
`ifdef FORWARD_EN
  assign load_use = (state_q == RUN) & IdValid & ex_mem_read_q & (ex_rs | rt_used & ex_rt);
  assign hazard = load_use;
  assign rs_fwd = !rs_nz ? '0 : ex_rs & ex_reg_write_q & ~ex_mem_read_q ? ExResult :
                  mem_rs ? MemResult : wb_rs ? WbData : RsData;
  assign rt_fwd = !rt_nz ? '0 : ex_rt & ex_reg_write_q & ~ex_mem_read_q ? ExResult :
                  mem_rt ? MemResult : wb_rt ? WbData : RtData;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ExResult, MemResult, WbData};
  assign load_use = 1'b0;
  assign hazard = IdValid & (ex_rs & ex_reg_write_q | mem_rs | wb_rs |
                             rt_used & (ex_rt & ex_reg_write_q | mem_rt | wb_rt));
  assign rs_fwd = rs_nz ? RsData : '0;
  assign rt_fwd = rt_nz ? RtData : '0;
`endif
  assign Hold = (hazard | DownStall) & ~Flush;
  // Flush squashes, downstream stall holds, a hazard inserts a counted bubble, otherwise capture decode
  always_comb begin
    state_d = state_q;
    ex_valid_d = ex_valid_q;
    ex_rd_d = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d = ex_mem_read_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    rt_val_d = rt_val_q;
    cnt_d = cnt_q;
    if (Flush) begin
      ex_valid_d = 1'b0;
      state_d = RUN;
    end else if (!DownStall && hazard) begin
      ex_valid_d = 1'b0;
      ex_rd_d = '0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d = 1'b0;
      op_a_d = '0;
      op_b_d = '0;
      rt_val_d = '0;
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      state_d = load_use ? LSTALL : RUN;
    end else if (!DownStall) begin
      ex_valid_d = IdValid;
      ex_rd_d = RdAddr;
      ex_reg_write_d = IdRegWrite;
      ex_mem_read_d = IdMemRead;
      op_a_d = rs_fwd;
      op_b_d = IdImmSel ? IdImm : rt_fwd;
      rt_val_d = rt_fwd;
      state_d = RUN;
    end
  end
  // Pipeline register, FSM and stall counter; reset empties the slot immediately
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= RUN;
      ex_valid_q <= 1'b0;
      ex_rd_q <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      rt_val_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q <= ex_mem_read_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      rt_val_q <= rt_val_d;
      cnt_q <= cnt_d;
    end
  end
  assign ExValid = ex_valid_q;
  assign ExRdAddr = ex_rd_q;
  assign ExRegWrite = ex_reg_write_q;
  assign ExMemRead = ex_mem_read_q;
  assign ExOpA = op_a_q;
  assign ExOpB = op_b_q;
  assign ExRtVal = rt_val_q;
  assign StallCount = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, directed hazard sequences and randomized model check for id_ex_stage
module tb_id_ex_stage;
  localparam int CW = 4;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic Clock = 1'b0;
  logic nReset = 1'b0;
  logic IdValid, IdRegWrite, IdMemRead, IdImmSel, MemRegWrite, WbRegWrite, DownStall, Flush;
  logic [4:0] RsAddr, RtAddr, RdAddr, MemRdAddr, WbRdAddr;
  logic [31:0] RsData, RtData, IdImm, ExResult, MemResult, WbData;
  logic ExValid, ExRegWrite, ExMemRead, Hold;
  logic [4:0] ExRdAddr;
  logic [31:0] ExOpA, ExOpB, ExRtVal;
  logic [CW-1:0] StallCount;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  id_ex_stage #(.CNT_W(CW)) dut (
    .Clock(Clock), .nReset(nReset), .IdValid(IdValid), .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RdAddr(RdAddr), .RsData(RsData), .RtData(RtData), .IdRegWrite(IdRegWrite),
    .IdMemRead(IdMemRead), .IdImm(IdImm), .IdImmSel(IdImmSel), .ExResult(ExResult),
    .MemRegWrite(MemRegWrite), .MemRdAddr(MemRdAddr), .MemResult(MemResult),
    .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr), .WbData(WbData), .DownStall(DownStall),
    .Flush(Flush), .ExValid(ExValid), .ExRdAddr(ExRdAddr), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExOpA(ExOpA), .ExOpB(ExOpB), .ExRtVal(ExRtVal), .Hold(Hold),
    .StallCount(StallCount)
  );

  typedef struct packed {
    logic v;
    logic [4:0] rd;
    logic rw;
    logic mr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
  } ex_t;
  ex_t m;
  logic [CW-1:0] m_cnt;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic isel;
    logic rw;
    logic mrw;
    logic [4:0] mrd;
    logic [31:0] mres;
    logic wrw;
    logic [4:0] wrd;
    logic [31:0] wd;
    logic hold;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rtv;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit writes(input logic en, input logic [4:0] rd, input logic [4:0] a);
    return en && (|a) && rd == a;
  endfunction

  function automatic bit rt_used_m();
    return !IdImmSel || (!IdRegWrite && !IdMemRead);
  endfunction

  // value an operand should carry: newest in-flight producer wins, $0 is always zero
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (!(|a)) return 32'h0;
    if (FWD) begin
      if (writes(m.v && m.rw && !m.mr, m.rd, a)) return ExResult;
      if (writes(MemRegWrite, MemRdAddr, a)) return MemResult;
      if (writes(WbRegWrite, WbRdAddr, a)) return WbData;
    end
    return rf;
  endfunction

  // a source is unavailable: only a load in EX with forwarding, any in-flight writer without
  function automatic bit busy(input logic [4:0] a);
    if (FWD) return m.v && m.mr && (|a) && m.rd == a;
    return writes(m.v && m.rw, m.rd, a) || writes(MemRegWrite, MemRdAddr, a) || writes(WbRegWrite, WbRdAddr, a);
  endfunction

  function automatic bit stall_m();
    return IdValid && (busy(RsAddr) || (rt_used_m() && busy(RtAddr)));
  endfunction

  task automatic clear_inputs();
    {IdValid, IdRegWrite, IdMemRead, IdImmSel, MemRegWrite, WbRegWrite, DownStall, Flush} = '0;
    {RsAddr, RtAddr, RdAddr, MemRdAddr, WbRdAddr} = '0;
    {RsData, RtData, IdImm, ExResult, MemResult, WbData} = '0;
  endtask

  task automatic tick(input string tag);
    ex_t nx;
    #1;
    check({tag, " Hold"}, 32'(Hold), 32'((stall_m() || DownStall) && !Flush));
    nx = m;
    if (Flush) nx.v = 1'b0;
    else if (!DownStall && stall_m()) begin
      nx = '0;
      if (m_cnt != '1) m_cnt++;
    end else if (!DownStall)
      nx = '{IdValid, RdAddr, IdRegWrite, IdMemRead, operand(RsAddr, RsData),
             IdImmSel ? IdImm : operand(RtAddr, RtData), operand(RtAddr, RtData)};
    @(posedge Clock);
    m = nx;
    #1;
    check({tag, " ExValid"}, 32'(ExValid), 32'(m.v));
    check({tag, " ExRdAddr"}, 32'(ExRdAddr), 32'(m.rd));
    check({tag, " ExRegWrite"}, 32'(ExRegWrite), 32'(m.rw));
    check({tag, " ExMemRead"}, 32'(ExMemRead), 32'(m.mr));
    check({tag, " ExOpA"}, ExOpA, m.a);
    check({tag, " ExOpB"}, ExOpB, m.b);
    check({tag, " ExRtVal"}, ExRtVal, m.rt);
    check({tag, " StallCount"}, 32'(StallCount), 32'(m_cnt));
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    clear_inputs();
    #1;
    m = '0;
    m_cnt = '0;
    check("rst ExValid", 32'(ExValid), 32'h0);
    check("rst ExRdAddr", 32'(ExRdAddr), 32'h0);
    check("rst ExRegWrite", 32'(ExRegWrite), 32'h0);
    check("rst ExMemRead", 32'(ExMemRead), 32'h0);
    check("rst ExOpA", ExOpA, 32'h0);
    check("rst ExOpB", ExOpB, 32'h0);
    check("rst ExRtVal", ExRtVal, 32'h0);
    check("rst Hold", 32'(Hold), 32'h0);
    check("rst StallCount", 32'(StallCount), 32'h0);
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic set_id(input logic [4:0] rs, rt, rd, input logic rw, mr, isel);
    IdValid = 1'b1;
    RsAddr = rs;
    RtAddr = rt;
    RdAddr = rd;
    IdRegWrite = rw;
    IdMemRead = mr;
    IdImmSel = isel;
  endtask

  // producer writes rd, consumer reads rd as Rs (and crt as Rt); the producer walks EX->MEM->WB->regfile
  task automatic run_raw(input string tag, input bit is_load, input logic [4:0] rd, crt,
                         input logic [31:0] res, input int exp_bub);
    int age;
    int bub;
    bit done;
    do_reset();
    set_id(5'd1, 5'd2, rd, 1'b1, is_load, is_load);
    IdImm = 32'h100;
    RsData = 32'h1000;
    ExResult = 32'h0;
    tick({tag, " prod"});
    set_id(rd, crt, rd + 5'd1, 1'b1, 1'b0, 1'b0);
    age = 0;
    bub = 0;
    done = 1'b0;
    for (int c = 0; c < 6 && !done; c++) begin
      ExResult = age == 0 ? (is_load ? 32'h1100 : res) : 32'hBAD0;
      MemRegWrite = age == 1;
      MemRdAddr = age == 1 ? rd : 5'd0;
      MemResult = age == 1 ? res : 32'hBAD1;
      WbRegWrite = age == 2;
      WbRdAddr = age == 2 ? rd : 5'd0;
      WbData = age == 2 ? res : 32'hBAD2;
      RsData = age >= 3 ? res : 32'hBAD3;
      RtData = crt == rd ? RsData : 32'h7;
      done = !stall_m();
      #1;
      if (Hold) bub++;
      tick({tag, " cons"});
      age++;
    end
    check({tag, " bubbles"}, 32'(bub), 32'(exp_bub));
    check({tag, " StallCount"}, 32'(StallCount), 32'(exp_bub));
    check({tag, " ExValid"}, 32'(ExValid), 32'h1);
    check({tag, " ExOpA"}, ExOpA, res);
    check({tag, " ExOpB"}, ExOpB, crt == rd ? res : 32'h7);
  endtask

  initial begin
    vt[0] = '{5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h11, 32'h22, 32'h22};
    vt[1] = '{5'd1, 5'd2, 32'h11, 32'h22, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h11, 32'hFFFFFFF0, 32'h22};
    vt[2] = '{5'd7, 5'd2, 32'h0, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55,
              !FWD, FWD ? 32'h55 : 32'h0, FWD ? 32'h22 : 32'h0, FWD ? 32'h22 : 32'h0};
    vt[3] = '{5'd0, 5'd2, 32'hAB, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h0, 32'h22, 32'h22};
    vt[4] = '{5'd9, 5'd2, 32'h1, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h77,
              !FWD, FWD ? 32'h99 : 32'h0, FWD ? 32'h22 : 32'h0, FWD ? 32'h22 : 32'h0};
    vt[5] = '{5'd1, 5'd9, 32'h11, 32'h3, 32'h40, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h11, 32'h40, FWD ? 32'h99 : 32'h3};
    vt[6] = '{5'd4, 5'd6, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hB6,
              !FWD, FWD ? 32'hA4 : 32'h0, FWD ? 32'hB6 : 32'h0, FWD ? 32'hB6 : 32'h0};
    do_reset();
    tick("idle");
    for (int i = 0; i < 7; i++) begin
      set_id(vt[i].rs, vt[i].rt, 5'd0, vt[i].rw, 1'b0, vt[i].isel);
      RsData = vt[i].rsd;
      RtData = vt[i].rtd;
      IdImm = vt[i].imm;
      MemRegWrite = vt[i].mrw;
      MemRdAddr = vt[i].mrd;
      MemResult = vt[i].mres;
      WbRegWrite = vt[i].wrw;
      WbRdAddr = vt[i].wrd;
      WbData = vt[i].wd;
      #1;
      check($sformatf("vec%0d Hold", i), 32'(Hold), 32'(vt[i].hold));
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d ExValid", i), 32'(ExValid), 32'(!vt[i].hold));
      check($sformatf("vec%0d ExOpA", i), ExOpA, vt[i].a);
      check($sformatf("vec%0d ExOpB", i), ExOpB, vt[i].b);
      check($sformatf("vec%0d ExRtVal", i), ExRtVal, vt[i].rtv);
    end
    run_raw("alu_raw", 1'b0, 5'd3, 5'd3, 32'h10, FWD ? 0 : 3);
    run_raw("load_use", 1'b1, 5'd5, 5'd1, 32'hDEADBEEF, FWD ? 1 : 3);
    // flush while downstream stalls right after a load-use bubble
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
    tick("fl load");
    set_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    tick("fl bubble");
    check("fl bubble ExValid", 32'(ExValid), 32'h0);
    MemRegWrite = 1'b1;
    MemRdAddr = 5'd5;
    MemResult = 32'hDEADBEEF;
    DownStall = 1'b1;
    Flush = 1'b1;
    #1;
    check("fl Hold", 32'(Hold), 32'h0);
    tick("fl flush");
    check("fl ExValid", 32'(ExValid), 32'h0);
    clear_inputs();
    set_id(5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1);
    RsData = 32'h42;
    #1;
    check("fl after Hold", 32'(Hold), 32'h0);
    tick("fl after");
    check("fl after ExValid", 32'(ExValid), 32'h1);
    check("fl after ExOpA", ExOpA, 32'h42);
    // load-use under downstream stall holds without counting, then bubbles once
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
    tick("ds load");
    set_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    DownStall = 1'b1;
    #1;
    check("ds Hold", 32'(Hold), 32'h1);
    tick("ds hold");
    check("ds ExValid", 32'(ExValid), 32'h1);
    check("ds ExMemRead", 32'(ExMemRead), 32'h1);
    check("ds ExRdAddr", 32'(ExRdAddr), 32'h5);
    check("ds StallCount", 32'(StallCount), 32'h0);
    DownStall = 1'b0;
    tick("ds release");
    check("ds bubble ExValid", 32'(ExValid), 32'h0);
    check("ds bubble StallCount", 32'(StallCount), 32'h1);
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
    tick("ds load2");
    set_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    DownStall = 1'b1;
    tick("ds hold2");
    #2;
    nReset = 1'b0;
    #1;
    check("midrst ExValid", 32'(ExValid), 32'h0);
    check("midrst ExMemRead", 32'(ExMemRead), 32'h0);
    check("midrst StallCount", 32'(StallCount), 32'h0);
    // counter saturation with a narrow counter
    do_reset();
    for (int k = 0; k < 20; k++) begin
      set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
      tick("sat load");
      set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
      tick("sat use");
      check("sat StallCount", 32'(StallCount), k < 15 ? 32'(k + 1) : 32'hF);
    end
    // randomized traffic against the model
    for (int r = 0; r < 600; r++) begin
      if (r % 150 == 0) do_reset();
      IdValid = $urandom_range(0, 99) < 75;
      RsAddr = 5'($urandom_range(0, 3));
      RtAddr = 5'($urandom_range(0, 3));
      RdAddr = 5'($urandom_range(0, 3));
      RsData = $urandom;
      RtData = $urandom;
      IdImm = $urandom;
      IdImmSel = $urandom_range(0, 99) < 30;
      IdRegWrite = $urandom_range(0, 99) < 70;
      IdMemRead = $urandom_range(0, 99) < 25;
      ExResult = $urandom;
      MemRegWrite = $urandom_range(0, 99) < 40;
      MemRdAddr = 5'($urandom_range(0, 3));
      MemResult = $urandom;
      WbRegWrite = $urandom_range(0, 99) < 40;
      WbRdAddr = 5'($urandom_range(0, 3));
      WbData = $urandom;
      DownStall = $urandom_range(0, 99) < 15;
      Flush = $urandom_range(0, 99) < 8;
      tick("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
